dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The parameter LINES SHALL default to 32 and SHALL set the number of direct-mapped one-word lines (power of two, 2..256).
REQ-002 The port clk SHALL be a 1-bit input and the single clock; all state SHALL update on its rising edge.
REQ-003 The port rst SHALL be a 1-bit input, synchronous, active-high reset.
REQ-004 The port MemReadM SHALL be a 1-bit input carrying the M-stage load request.
REQ-005 The port MemWriteM SHALL be a 1-bit input carrying the M-stage store request.
REQ-006 The port ALUResultM SHALL be a 32-bit input carrying the byte address (word aligned; bits [1:0] ignored).
REQ-007 The port WriteDataM SHALL be a 32-bit input carrying the store data.
REQ-008 The port ReadDataM SHALL be a 32-bit output carrying the load data.
REQ-009 The port Mem_Stall SHALL be a 1-bit output that freezes all pipeline registers while high.
REQ-010 The ports mem_req (1-bit), mem_we (1-bit), mem_addr (32-bit) and mem_wdata (32-bit) SHALL be outputs forming the main-memory request.
REQ-011 The ports mem_rdata (32-bit) and mem_ready (1-bit) SHALL be inputs forming the main-memory response.
REQ-012 The ports hit_cnt and miss_cnt SHALL be 32-bit outputs carrying the performance counters.

Function
REQ-013 Address split SHALL be: index = ALUResultM[log2(LINES)+1:2], tag = the remaining upper bits; each line holds valid, tag and a 32-bit data word.
REQ-014 The FSM SHALL have exactly the states IDLE, FILL, WRITE and WDONE.
REQ-015 hit SHALL be valid[index] && tag match, evaluated combinationally.
REQ-016 When both MemReadM and MemWriteM are high, the store SHALL take priority.
REQ-017 In IDLE with a load hit, ReadDataM SHALL be the line data in the same cycle, Mem_Stall SHALL be 0 and hit_cnt SHALL increment.
REQ-018 In IDLE with a load miss, Mem_Stall SHALL be 1 combinationally, miss_cnt SHALL increment and the next state SHALL be FILL.
REQ-019 In FILL, outputs SHALL be mem_req=1, mem_we=0, mem_addr={ALUResultM[31:2],2'b00} and Mem_Stall=1.
REQ-020 In FILL, on the edge where mem_ready=1 the line SHALL be written (valid=1, tag, mem_rdata) and the next state SHALL be IDLE, where the retried load hits.
REQ-021 In IDLE with a store, Mem_Stall SHALL be 1 and the next state SHALL be WRITE; the store SHALL count as a hit or miss per REQ-015.
REQ-022 In WRITE (write-through, no-write-allocate), outputs SHALL be mem_req=1, mem_we=1 and mem_wdata=WriteDataM with Mem_Stall=1.
REQ-023 In WRITE, on the edge with mem_ready=1 the line data SHALL be updated only if hit, and the next state SHALL be WDONE.
REQ-024 WDONE SHALL last exactly one cycle with Mem_Stall=0 and mem_req=0, ignore MemReadM/MemWriteM, and go to IDLE.
REQ-025 mem_req and its address/data SHALL stay stable until mem_ready is sampled high; mem_ready outside FILL/WRITE SHALL be ignored.
REQ-026 When neither MemReadM nor MemWriteM is high in IDLE, there SHALL be no stall and no counter change.
REQ-027 ReadDataM SHALL be 0 whenever no load hit is being served.
REQ-028 Both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-029 Stall length SHALL be: load miss = k+1 cycles and store = k+1 cycles, where k is the number of FILL/WRITE cycles up to and including the mem_ready cycle.

Reset
REQ-030 rst SHALL clear all valid bits, set the state to IDLE and zero hit_cnt and miss_cnt, with mem_req=0 in the following cycle.
REQ-031 rst asserted in FILL or WRITE SHALL abandon the transfer and leave no line written.
REQ-032 rst SHALL take priority over every other event in the same cycle.

Verification
REQ-033 Bench: after reset, load 0x40 with memory returning 0xDEADBEEF and mem_ready in the 3rd FILL cycle -> Mem_Stall high 4 cycles, then ReadDataM=0xDEADBEEF, miss_cnt=1.
REQ-034 Bench: repeat load 0x40 -> Mem_Stall=0 in the same cycle, ReadDataM=0xDEADBEEF, hit_cnt=1, mem_req never high.
REQ-035 Bench: store 0x12345678 to 0x40 with mem_ready in the 1st WRITE cycle -> mem_we=1, mem_addr=0x40, Mem_Stall high 2 cycles, then WDONE low; a subsequent load returns 0x12345678 with no miss.
REQ-036 Bench: store to uncached 0x80, then load 0x80 -> the load misses (no-write-allocate) and the fill occurs.
REQ-037 Bench: load 0x40 then 0x40+4*LINES (same index, different tag) -> the second load misses and evicts the first line; reloading 0x40 misses again.
REQ-038 Bench: rst pulsed in the 2nd FILL cycle -> mem_req=0 next cycle, valid cleared, counters 0, and the later load of the same address misses.
REQ-039 Bench: MemReadM and MemWriteM both high -> WRITE path taken, no FILL.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache controller
// for the M stage, with blocking main-memory handshake and hit/miss performance counters.
module dcache_ctrl #(
    parameter int LINES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        Mem_Stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;

    state_t            state, state_nxt;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [31:0]       data_mem [LINES];
    logic              just_filled;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit;
    logic              is_store, is_load;
    logic              count_hit, count_miss, fill_we, wr_we;
    logic              unused_addr_bits;

    assign idx              = ALUResultM[IDX_W+1:2];
    assign tag              = ALUResultM[31:IDX_W+2];
    assign hit              = valid[idx] && (tag_mem[idx] == tag);
    assign is_store         = MemWriteM;
    assign is_load          = MemReadM && !MemWriteM;
    assign unused_addr_bits = ^ALUResultM[1:0];

    always_comb begin
        state_nxt  = state;
        Mem_Stall  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        ReadDataM  = 32'd0;
        count_hit  = 1'b0;
        count_miss = 1'b0;
        fill_we    = 1'b0;
        wr_we      = 1'b0;
        case (state)
            IDLE: begin
                if (is_store) begin
                    Mem_Stall  = 1'b1;
                    count_hit  = hit;
                    count_miss = !hit;
                    state_nxt  = WRITE;
                end else if (is_load) begin
                    if (hit) begin
                        ReadDataM = data_mem[idx];
                        // the retried load right after a refill was already counted as a miss
                        count_hit = !just_filled;
                    end else begin
                        Mem_Stall  = 1'b1;
                        count_miss = 1'b1;
                        state_nxt  = FILL;
                    end
                end
            end
            FILL: begin
                Mem_Stall = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = {ALUResultM[31:2], 2'b00};
                if (mem_ready) begin
                    fill_we   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                Mem_Stall = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {ALUResultM[31:2], 2'b00};
                mem_wdata = WriteDataM;
                if (mem_ready) begin
                    wr_we     = hit;
                    state_nxt = WDONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            valid       <= '0;
            hit_cnt     <= 32'd0;
            miss_cnt    <= 32'd0;
            just_filled <= 1'b0;
        end else begin
            state       <= state_nxt;
            just_filled <= fill_we;
            if (fill_we)
                valid[idx] <= 1'b1;
            if (count_hit)
                hit_cnt <= hit_cnt + 32'd1;
            if (count_miss)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end

    // Line storage is not reset; gating with rst keeps an abandoned transfer from landing.
    always_ff @(posedge clk) begin
        if (!rst && fill_we) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= mem_rdata;
        end else if (!rst && wr_we) begin
            data_mem[idx] <= WriteDataM;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus random traffic
// compared against an array-based cache model with a programmable memory responder.
module tb_dcache_ctrl;
    localparam int L  = 32;
    localparam int IW = $clog2(L);

    logic        clk = 0;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        Mem_Stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] hit_cnt, miss_cnt;

    int total = 0;
    int bad   = 0;

    bit          mv [L];
    logic [31:0] mt [L];
    logic [31:0] md [L];
    logic [31:0] hc, mc;

    dcache_ctrl #(.LINES(L)) dut (
        .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
        .Mem_Stall(Mem_Stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < L; i++) mv[i] = 0;
        hc = 0;
        mc = 0;
    endtask

    // One M-stage access, held until the stall drops; expectations come from the model.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input int dly, input logic [31:0] mval);
        int idx, exp_stall, exp_req, stalls, reqs;
        logic [31:0] tg, exp_rd, got_rd;
        bit mhit, done, badbus, final_req;
        idx  = int'((a >> 2) % L);
        tg   = a >> (2 + IW);
        mhit = mv[idx] && (mt[idx] == tg);
        if (!rd && !wr) begin
            exp_stall = 0; exp_req = 0; exp_rd = 0;
        end else if (wr) begin
            exp_stall = dly + 1; exp_req = dly; exp_rd = 0;
            if (mhit) hc++; else mc++;
        end else if (mhit) begin
            exp_stall = 0; exp_req = 0; exp_rd = md[idx]; hc++;
        end else begin
            exp_stall = dly + 1; exp_req = dly; exp_rd = mval; mc++;
        end
        MemReadM = rd; MemWriteM = wr; ALUResultM = a; WriteDataM = wd; mem_ready = 0;
        stalls = 0; reqs = 0; done = 0; badbus = 0; got_rd = 0; final_req = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mem_req) begin
                reqs++;
                if (mem_we !== wr || mem_addr !== {a[31:2], 2'b00} || (wr && mem_wdata !== wd))
                    badbus = 1;
                if (reqs == dly) begin
                    mem_ready = 1;
                    mem_rdata = mval;
                end
            end
            if (Mem_Stall) stalls++;
            else begin
                done = 1; got_rd = ReadDataM; final_req = mem_req;
            end
            @(posedge clk); #1;
            mem_ready = 0;
            mem_rdata = $urandom;
        end
        MemReadM = 0; MemWriteM = 0;
        if (rd && !wr && !mhit) begin
            mv[idx] = 1; mt[idx] = tg; md[idx] = mval;
        end else if (wr && mhit) begin
            md[idx] = wd;
        end
        total++;
        if (!done) begin
            bad++; $display("FAIL access_timeout addr=%h stall never dropped", a);
        end
        total++;
        if (stalls !== exp_stall) begin
            bad++; $display("FAIL stall_len addr=%h rd=%0d wr=%0d got=%0d exp=%0d", a, rd, wr, stalls, exp_stall);
        end
        total++;
        if (reqs !== exp_req) begin
            bad++; $display("FAIL req_cycles addr=%h got=%0d exp=%0d", a, reqs, exp_req);
        end
        total++;
        if (got_rd !== exp_rd) begin
            bad++; $display("FAIL read_data addr=%h got=%h exp=%h", a, got_rd, exp_rd);
        end
        total++;
        if (badbus || final_req !== 1'b0) begin
            bad++; $display("FAIL mem_bus addr=%h badbus=%0d final_req=%0d exp 0/0", a, badbus, final_req);
        end
        @(negedge clk);
        total++;
        if (hit_cnt !== hc || miss_cnt !== mc) begin
            bad++; $display("FAIL counters hit=%0d miss=%0d exp hit=%0d miss=%0d", hit_cnt, miss_cnt, hc, mc);
        end
        total++;
        if (Mem_Stall !== 1'b0 || ReadDataM !== 32'd0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL idle_quiet stall=%0d rd=%h req=%0d exp 0", Mem_Stall, ReadDataM, mem_req);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1; MemReadM = 0; MemWriteM = 0; ALUResultM = 0; WriteDataM = 0;
        mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_clear();
        @(negedge clk);
        total++;
        if (hit_cnt !== 0 || miss_cnt !== 0 || mem_req !== 0 || Mem_Stall !== 0 || ReadDataM !== 0) begin
            bad++; $display("FAIL reset_state hit=%0d miss=%0d req=%0d stall=%0d rd=%h exp all 0",
                            hit_cnt, miss_cnt, mem_req, Mem_Stall, ReadDataM);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (hit_cnt !== 0 || miss_cnt !== 0 || mem_req !== 0 || Mem_Stall !== 0) begin
            bad++; $display("FAIL stray_ready hit=%0d miss=%0d req=%0d stall=%0d exp 0",
                            hit_cnt, miss_cnt, mem_req, Mem_Stall);
        end
        @(posedge clk); #1 mem_ready = 0;
    endtask

    task automatic test_directed();
        access(1, 0, 32'h40, 0, 3, 32'hDEADBEEF);
        total++;
        if (miss_cnt !== 1) begin
            bad++; $display("FAIL first_miss miss_cnt=%0d exp 1", miss_cnt);
        end
        access(1, 0, 32'h40, 0, 1, 32'h0);
        total++;
        if (hit_cnt !== 1) begin
            bad++; $display("FAIL repeat_hit hit_cnt=%0d exp 1", hit_cnt);
        end
        access(0, 1, 32'h40, 32'h12345678, 1, 32'h0);
        access(1, 0, 32'h40, 0, 1, 32'h0);
        access(0, 1, 32'h80, 32'hCAFE0080, 2, 32'h0);
        access(1, 0, 32'h80, 0, 2, 32'h8080_8080);
        access(1, 0, 32'h40 + 4 * L, 0, 1, 32'hA5A5_0001);
        access(1, 0, 32'h40, 0, 2, 32'h5A5A_0002);
        access(1, 1, 32'h44, 32'h0B0B_0044, 3, 32'h0);
        access(0, 0, 32'h40, 0, 1, 32'h0);
    endtask

    task automatic test_reset_in_fill();
        int reqs;
        bit hit_point;
        MemReadM = 1; MemWriteM = 0; ALUResultM = 32'h100; mem_ready = 0;
        reqs = 0; hit_point = 0;
        for (int c = 0; c < 20 && !hit_point; c++) begin
            @(negedge clk);
            if (mem_req) reqs++;
            if (reqs == 2) begin
                rst = 1; hit_point = 1;
            end
            @(posedge clk); #1;
        end
        rst = 0; MemReadM = 0;
        model_clear();
        total++;
        if (!hit_point) begin
            bad++; $display("FAIL fill_reach never saw 2nd fill cycle, reqs=%0d", reqs);
        end
        @(negedge clk);
        total++;
        if (mem_req !== 0 || hit_cnt !== 0 || miss_cnt !== 0) begin
            bad++; $display("FAIL reset_in_fill req=%0d hit=%0d miss=%0d exp 0", mem_req, hit_cnt, miss_cnt);
        end
        @(posedge clk); #1;
        access(1, 0, 32'h40, 0, 1, 32'h1111_0040);
        access(1, 0, 32'h100, 0, 1, 32'h2222_0100);
    endtask

    task automatic test_random();
        for (int n = 0; n < 250; n++) begin
            int op;
            logic [31:0] a;
            op = $urandom_range(0, 3);
            a = ($urandom_range(0, 3) << (2 + IW)) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            access(op[0], op[1], a, $urandom, $urandom_range(1, 4), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_in_fill();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
